// File: rtl/mux_nto1_rr_pkg.sv
// Shared constants for the N:1 round-robin / fixed-select mux.
// Mode encoding, output-register state encoding and the select-width helper.
// Pure package: no logic, no latency, no flow control.
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1_rr_arbiter.sv
// Rotating-priority arbiter: first requester at or after ptr wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; enable=0 forces an all-zero grant.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      // ptr never exceeds N-1, so one subtraction is enough to wrap
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (enable && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = SEL_W'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-channel W-bit mux, round-robin or fixed select, registered output (MUX_PARITY_EN adds Y_par).
// Latency: 1 cycle from transfer to Y/Y_valid; one word per cycle sustained.
// Backpressure: Y full and Y_ready=0 holds Y and drives all A_ready low.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 2,
  parameter int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   A,
  input  logic [N-1:0]     A_valid,
  output logic [N-1:0]     A_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     Y,
  output logic             Y_valid,
`ifdef MUX_PARITY_EN
  output logic             Y_par,
`endif
  input  logic             Y_ready
);

  logic [0:0]       st;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [N-1:0]     rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic [N-1:0]     fix_gnt;
  logic [N-1:0]     gnt;
  logic [W-1:0]     d;
  logic             load;
  logic             xfer;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req     (A_valid),
    .ptr     (ptr),
    .enable  (mode == MODE_RR),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Out-of-range sel simply matches no channel
  always_comb begin
    for (int i = 0; i < N; i++) begin
      fix_gnt[i] = (int'(sel) == i) && A_valid[i];
    end
  end

  assign gnt     = (mode == MODE_FIXED) ? fix_gnt : rr_gnt;
  assign load    = rst_n && ((st == ST_EMPTY) || Y_ready);
  assign A_ready = load ? gnt : '0;
  assign xfer    = load && (|gnt);
  assign Y_valid = (st == ST_FULL);
  assign ptr_nxt = (int'(rr_idx) == N - 1) ? '0 : rr_idx + SEL_W'(1);

  always_comb begin
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) d = d | A[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= ST_EMPTY;
      Y   <= '0;
      ptr <= '0;
`ifdef MUX_PARITY_EN
      Y_par <= 1'b0;
`endif
    end else if (xfer) begin
      st <= ST_FULL;
      Y  <= d;
`ifdef MUX_PARITY_EN
      Y_par <= ^d;
`endif
      if (mode == MODE_RR) ptr <= ptr_nxt;
    end else if (Y_ready) begin
      // drained with nothing to refill: Y keeps its last value
      st <= ST_EMPTY;
    end
  end

endmodule
